// File: rtl/rv_axi4_lite_pkg.sv
// Shared AXI4-Lite types for the arbiter slice: channel payload structs,
// response codes and the per-path arbiter state encodings.
package rv_axi4_lite_pkg;

    localparam int RV_AXI4_LITE_ADDR_WIDTH = 32;
    localparam int RV_AXI4_LITE_DATA_WIDTH = 32;
    localparam int RV_AXI4_LITE_STRB_WIDTH = RV_AXI4_LITE_DATA_WIDTH / 8;

    typedef logic [2:0] rv_axi4_lite_prot;
    typedef logic [1:0] rv_axi4_lite_resp;

    localparam rv_axi4_lite_resp RESP_OKAY   = 2'b00;
    localparam rv_axi4_lite_resp RESP_EXOKAY = 2'b01;
    localparam rv_axi4_lite_resp RESP_SLVERR = 2'b10;
    localparam rv_axi4_lite_resp RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_RESP
    } rv_axi4_lite_arb_wr_state;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_ADDR,
        RD_DATA
    } rv_axi4_lite_arb_rd_state;

    typedef struct packed {
        logic [RV_AXI4_LITE_ADDR_WIDTH-1:0] addr;
        rv_axi4_lite_prot                   prot;
    } rv_axi4_lite_aw;

    typedef rv_axi4_lite_aw rv_axi4_lite_ar;

    typedef struct packed {
        logic [RV_AXI4_LITE_DATA_WIDTH-1:0] data;
        logic [RV_AXI4_LITE_STRB_WIDTH-1:0] strb;
    } rv_axi4_lite_w;

    typedef struct packed {
        logic [RV_AXI4_LITE_DATA_WIDTH-1:0] data;
        rv_axi4_lite_resp                   resp;
    } rv_axi4_lite_r;

endpackage

// File: rtl/rv_axi4_lite_rr_picker.sv
// Combinational round-robin picker: first asserted request searching upward
// from last+1, wrapping at NUM_MASTERS.
module rv_axi4_lite_rr_picker #(
    parameter int NUM_MASTERS = 2
) (
    input  logic [NUM_MASTERS-1:0]         req,
    input  logic [$clog2(NUM_MASTERS)-1:0] last,
    output logic                           valid,
    output logic [$clog2(NUM_MASTERS)-1:0] grant
);

    localparam int IDX_WIDTH = $clog2(NUM_MASTERS);

    logic [IDX_WIDTH-1:0] idx;

    // Scanning from the farthest offset down lets the nearest requester win last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            idx = IDX_WIDTH'((int'(last) + off) % NUM_MASTERS);
            if (req[idx]) begin
                valid = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/rv_axi4_lite_arbiter.sv
// AXI4-Lite N:1 arbiter with independent round-robin write (AW/W/B) and read (AR/R)
// paths, one outstanding transaction per path, responses routed to the granted master.
module rv_axi4_lite_arbiter
    import rv_axi4_lite_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                                          clk,
    input  logic                                          rst,

    input  logic [NUM_MASTERS-1:0]                        s_awvalid,
    output logic [NUM_MASTERS-1:0]                        s_awready,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]        s_awaddr,
    input  rv_axi4_lite_prot [NUM_MASTERS-1:0]            s_awprot,
    input  logic [NUM_MASTERS-1:0]                        s_wvalid,
    output logic [NUM_MASTERS-1:0]                        s_wready,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        s_wdata,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]      s_wstrb,
    output logic [NUM_MASTERS-1:0]                        s_bvalid,
    input  logic [NUM_MASTERS-1:0]                        s_bready,
    output rv_axi4_lite_resp [NUM_MASTERS-1:0]            s_bresp,
    input  logic [NUM_MASTERS-1:0]                        s_arvalid,
    output logic [NUM_MASTERS-1:0]                        s_arready,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]        s_araddr,
    input  rv_axi4_lite_prot [NUM_MASTERS-1:0]            s_arprot,
    output logic [NUM_MASTERS-1:0]                        s_rvalid,
    input  logic [NUM_MASTERS-1:0]                        s_rready,
    output logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]        s_rdata,
    output rv_axi4_lite_resp [NUM_MASTERS-1:0]            s_rresp,

    output logic                                          m_awvalid,
    input  logic                                          m_awready,
    output logic [ADDR_WIDTH-1:0]                         m_awaddr,
    output rv_axi4_lite_prot                              m_awprot,
    output logic                                          m_wvalid,
    input  logic                                          m_wready,
    output logic [DATA_WIDTH-1:0]                         m_wdata,
    output logic [DATA_WIDTH/8-1:0]                       m_wstrb,
    input  logic                                          m_bvalid,
    output logic                                          m_bready,
    input  rv_axi4_lite_resp                              m_bresp,
    output logic                                          m_arvalid,
    input  logic                                          m_arready,
    output logic [ADDR_WIDTH-1:0]                         m_araddr,
    output rv_axi4_lite_prot                              m_arprot,
    input  logic                                          m_rvalid,
    output logic                                          m_rready,
    input  logic [DATA_WIDTH-1:0]                         m_rdata,
    input  rv_axi4_lite_resp                              m_rresp
);

    localparam int IDX_WIDTH = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || ADDR_WIDTH != RV_AXI4_LITE_ADDR_WIDTH ||
        DATA_WIDTH != RV_AXI4_LITE_DATA_WIDTH) begin : g_param_check
        $error("rv_axi4_lite_arbiter: unsupported parameter set");
    end

    rv_axi4_lite_arb_wr_state wr_state;
    rv_axi4_lite_arb_rd_state rd_state;
    logic [IDX_WIDTH-1:0]     wr_grant, wr_last, wr_pick;
    logic [IDX_WIDTH-1:0]     rd_grant, rd_last, rd_pick;
    logic                     wr_pick_valid, rd_pick_valid;
    logic                     aw_done, w_done;
    logic                     aw_done_next, w_done_next;

    rv_axi4_lite_aw aw_sel;
    rv_axi4_lite_w  w_sel;
    rv_axi4_lite_ar ar_sel;
    rv_axi4_lite_r  r_in;

    rv_axi4_lite_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_wr_picker (
        .req   (s_awvalid),
        .last  (wr_last),
        .valid (wr_pick_valid),
        .grant (wr_pick)
    );

    rv_axi4_lite_rr_picker #(.NUM_MASTERS(NUM_MASTERS)) u_rd_picker (
        .req   (s_arvalid),
        .last  (rd_last),
        .valid (rd_pick_valid),
        .grant (rd_pick)
    );

    assign aw_done_next = aw_done | (m_awvalid & m_awready);
    assign w_done_next  = w_done  | (m_wvalid  & m_wready);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state <= WR_IDLE;
            wr_grant <= '0;
            wr_last  <= IDX_WIDTH'(NUM_MASTERS - 1);
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            case (wr_state)
                WR_IDLE: if (wr_pick_valid) begin
                    wr_grant <= wr_pick;
                    wr_state <= WR_ADDR;
                end
                WR_ADDR: if (aw_done_next && w_done_next) begin
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    wr_state <= WR_RESP;
                end else begin
                    aw_done <= aw_done_next;
                    w_done  <= w_done_next;
                end
                WR_RESP: if (m_bvalid && m_bready) begin
                    wr_last  <= wr_grant;
                    wr_state <= WR_IDLE;
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            rd_grant <= '0;
            rd_last  <= IDX_WIDTH'(NUM_MASTERS - 1);
        end else begin
            case (rd_state)
                RD_IDLE: if (rd_pick_valid) begin
                    rd_grant <= rd_pick;
                    rd_state <= RD_ADDR;
                end
                RD_ADDR: if (m_arvalid && m_arready) rd_state <= RD_DATA;
                RD_DATA: if (m_rvalid && m_rready) begin
                    rd_last  <= rd_grant;
                    rd_state <= RD_IDLE;
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    // Write channel routing: payload follows the registered grant only.
    always_comb begin
        s_awready = '0;
        s_wready  = '0;
        s_bvalid  = '0;
        s_bresp   = '0;
        m_awvalid = 1'b0;
        m_awaddr  = '0;
        m_awprot  = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_bready  = 1'b0;
        aw_sel    = '{addr: s_awaddr[wr_grant], prot: s_awprot[wr_grant]};
        w_sel     = '{data: s_wdata[wr_grant], strb: s_wstrb[wr_grant]};
        case (wr_state)
            WR_ADDR: begin
                if (!aw_done) begin
                    m_awvalid           = s_awvalid[wr_grant];
                    m_awaddr            = aw_sel.addr;
                    m_awprot            = aw_sel.prot;
                    s_awready[wr_grant] = m_awready;
                end
                if (!w_done) begin
                    m_wvalid           = s_wvalid[wr_grant];
                    m_wdata            = w_sel.data;
                    m_wstrb            = w_sel.strb;
                    s_wready[wr_grant] = m_wready;
                end
            end
            WR_RESP: begin
                s_bvalid[wr_grant] = m_bvalid;
                s_bresp[wr_grant]  = m_bresp;
                m_bready           = s_bready[wr_grant];
            end
            default: ;
        endcase
    end

    always_comb begin
        s_arready = '0;
        s_rvalid  = '0;
        s_rdata   = '0;
        s_rresp   = '0;
        m_arvalid = 1'b0;
        m_araddr  = '0;
        m_arprot  = '0;
        m_rready  = 1'b0;
        ar_sel    = '{addr: s_araddr[rd_grant], prot: s_arprot[rd_grant]};
        r_in      = '{data: m_rdata, resp: m_rresp};
        case (rd_state)
            RD_ADDR: begin
                m_arvalid           = s_arvalid[rd_grant];
                m_araddr            = ar_sel.addr;
                m_arprot            = ar_sel.prot;
                s_arready[rd_grant] = m_arready;
            end
            RD_DATA: begin
                s_rvalid[rd_grant] = m_rvalid;
                s_rdata[rd_grant]  = r_in.data;
                s_rresp[rd_grant]  = r_in.resp;
                m_rready           = s_rready[rd_grant];
            end
            default: ;
        endcase
    end

endmodule
